// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one bit position per clock through a shared single-bit shifter.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables ROR on op 11; otherwise op 11 is rejected.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d;

  logic [31:0]      amt_ext;
  logic [CNT_W-1:0] n_eff;
  logic             reject;
  logic [WIDTH-1:0] step;

  // Effective step count for the incoming command; linear shifts saturate at WIDTH.
  always_comb begin
    amt_ext = 32'(in_amt);
    n_eff   = '0;
    reject  = 1'b0;
    case (in_op)
      OP_ROR: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        n_eff = CNT_W'(amt_ext % WIDTH);
`else
        reject = 1'b1;
`endif
      end
      default: begin
        n_eff = (amt_ext >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(amt_ext);
      end
    endcase
  end

  always_comb begin
    step = work_q;
    case (op_q)
      OP_SLL:  step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step = {work_q[0], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          op_d    = in_op;
          cnt_d   = n_eff;
          err_d   = reject;
          state_d = (n_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign out_data  = work_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4, AMT_W=4).
module tb_shift_seq_ctrl;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] a;
    logic [1:0] op;
    logic [3:0] exp;
    logic [2:0] nb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [3:0] in_amt = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.WIDTH(4), .AMT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Drives one command with out_ready=1 and reports result, busy cycles and latency (-1 = timeout).
  task automatic do_cmd(input logic [3:0] d, input logic [3:0] a, input logic [1:0] op,
                        output logic [3:0] res, output logic err, output int nbusy,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!out_valid && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    res = out_data;
    err = out_err;
    if (!out_valid) lat = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset out_data got %b exp 0000", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset out_err got %b exp 0", out_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_sra_basic();
    logic [3:0] res; logic err; int nb; int lat;
    do_cmd(4'b1100, 4'd1, SRA, res, err, nb, lat);
    checks++; if (res !== 4'b1110) begin errors++; $display("FAIL sra_basic data got %b exp 1110", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sra_basic err got %b exp 0", err); end
    checks++; if (nb != 1) begin errors++; $display("FAIL sra_basic busy_cycles got %0d exp 1", nb); end
    checks++; if (lat != 2) begin errors++; $display("FAIL sra_basic latency got %0d exp 2", lat); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL sra_basic return valid/ready got %b%b exp 01", out_valid, in_ready);
    end
  endtask

  task automatic test_shifts();
    vec_t tbl [10];
    logic [3:0] res; logic err; int nb; int lat;
    tbl[0] = {4'b1100, 4'd1,  SLL, 4'b1000, 3'd1};
    tbl[1] = {4'b1010, 4'd4,  SRL, 4'b0000, 3'd4};
    tbl[2] = {4'b1110, 4'd4,  SRA, 4'b1111, 3'd4};
    tbl[3] = {4'b0010, 4'd11, SLL, 4'b0000, 3'd4};
    tbl[4] = {4'b0110, 4'd2,  SRA, 4'b0001, 3'd2};
    tbl[5] = {4'b1000, 4'd15, SRA, 4'b1111, 3'd4};
    tbl[6] = {4'b1011, 4'd3,  SRL, 4'b0001, 3'd3};
    tbl[7] = {4'b1011, 4'd0,  SLL, 4'b1011, 3'd0};
    tbl[8] = {4'b1011, 4'd0,  SRL, 4'b1011, 3'd0};
    tbl[9] = {4'b1011, 4'd0,  SRA, 4'b1011, 3'd0};
    for (int i = 0; i < 10; i++) begin
      do_cmd(tbl[i].d, tbl[i].a, tbl[i].op, res, err, nb, lat);
      checks++; if (res !== tbl[i].exp) begin errors++; $display("FAIL shift[%0d] data got %b exp %b", i, res, tbl[i].exp); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL shift[%0d] err got %b exp 0", i, err); end
      checks++; if (nb != int'(tbl[i].nb)) begin errors++; $display("FAIL shift[%0d] busy_cycles got %0d exp %0d", i, nb, tbl[i].nb); end
      checks++; if (lat != int'(tbl[i].nb) + 1) begin errors++; $display("FAIL shift[%0d] latency got %0d exp %0d", i, lat, int'(tbl[i].nb) + 1); end
    end
  endtask

  task automatic test_op3();
    logic [3:0] res; logic err; int nb; int lat;
`ifdef SHIFT_SEQ_ROTATE_EN
    do_cmd(4'b1001, 4'd5, ROR, res, err, nb, lat);
    checks++; if (res !== 4'b1100) begin errors++; $display("FAIL ror5 data got %b exp 1100", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ror5 err got %b exp 0", err); end
    checks++; if (nb != 1 || lat != 2) begin errors++; $display("FAIL ror5 busy/lat got %0d/%0d exp 1/2", nb, lat); end
    do_cmd(4'b0110, 4'd3, ROR, res, err, nb, lat);
    checks++; if (res !== 4'b1100) begin errors++; $display("FAIL ror3 data got %b exp 1100", res); end
    checks++; if (nb != 3) begin errors++; $display("FAIL ror3 busy_cycles got %0d exp 3", nb); end
    do_cmd(4'b0001, 4'd4, ROR, res, err, nb, lat);
    checks++; if (res !== 4'b0001 || nb != 0) begin errors++; $display("FAIL ror4 data/busy got %b/%0d exp 0001/0", res, nb); end
`else
    do_cmd(4'b1001, 4'd5, ROR, res, err, nb, lat);
    checks++; if (res !== 4'b1001) begin errors++; $display("FAIL op3_reject data got %b exp 1001", res); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL op3_reject err got %b exp 1", err); end
    checks++; if (nb != 0 || lat != 1) begin errors++; $display("FAIL op3_reject busy/lat got %0d/%0d exp 0/1", nb, lat); end
    do_cmd(4'b0001, 4'd1, SLL, res, err, nb, lat);
    checks++; if (res !== 4'b0010) begin errors++; $display("FAIL after_reject data got %b exp 0010", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL after_reject err got %b exp 0", err); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1000; in_amt = 4'd1; in_op = SRL; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Second command held on the inputs while the first is in flight.
    in_data = 4'b0011; in_amt = 4'd1; in_op = SLL;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b shift busy/ready got %b%b exp 10", busy, in_ready); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 4'b0100 || in_ready !== 1'b0) begin
        errors++; $display("FAIL b2b stall[%0d] valid/data/ready got %b/%b/%b exp 1/0100/0", i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b handshake valid/ready/busy got %b%b%b exp 010", out_valid, in_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b second accept busy got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0110) begin
      errors++; $display("FAIL b2b second result valid/data got %b/%b exp 1/0110", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] res; logic err; int nb; int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0001; in_amt = 4'd3; in_op = SLL; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid pre busy got %b exp 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid ready/valid/busy got %b%b%b exp 100", in_ready, out_valid, busy);
    end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL rst_mid out_data got %b exp 0000", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid no partial result got valid %b", out_valid); end
    do_cmd(4'b1100, 4'd2, SRL, res, err, nb, lat);
    checks++; if (res !== 4'b0011 || nb != 2 || lat != 3) begin
      errors++; $display("FAIL rst_mid follow data/busy/lat got %b/%0d/%0d exp 0011/2/3", res, nb, lat);
    end
  endtask

  initial begin
    test_reset();
    test_sra_basic();
    test_shifts();
    test_op3();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
